// File: rtl/timer_pkg.sv
// Shared definitions for the tick timer: register map, CTRL/STATUS bit positions
// and the timer state encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_COUNT   = 2'd1;
  localparam logic [1:0] ADDR_COMPARE = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;

  localparam int STAT_PEND     = 0;
  localparam int STAT_OVF      = 1;
  localparam int STAT_MISS_CLR = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/tick_timer_irq.sv
// Tick-driven compare timer with level interrupt and a small register port.
// Optional TIMER_MISS_CNT_EN adds a saturating missed-match counter in STATUS[15:8].
module tick_timer_irq
  import timer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_i,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        irq_ack
);

  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] compare_q, compare_d;
  logic [CNT_W-1:0] count_inc_s;
  timer_state_e     state_q, state_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             irq_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_mux_s;
  logic [MISS_W-1:0] miss_s;
  logic             wr_ctrl_s, wr_count_s, wr_compare_s, wr_status_s;
  logic             counting_s, match_s, wrap_s;
  logic             unused_wdata_s;

  assign wr_ctrl_s    = wr_en && (addr == ADDR_CTRL);
  assign wr_count_s   = wr_en && (addr == ADDR_COUNT);
  assign wr_compare_s = wr_en && (addr == ADDR_COMPARE);
  assign wr_status_s  = wr_en && (addr == ADDR_STATUS);

  // A COUNT write on a tick cycle suppresses both the increment and the match.
  assign count_inc_s = count_q + CNT_W'(1);
  assign counting_s  = tick_i && (state_q == RUN) && !wr_count_s;
  assign match_s     = counting_s && (compare_q != '0) && (count_inc_s == compare_q);
  assign wrap_s      = counting_s && !match_s && (count_inc_s == '0);

  assign unused_wdata_s = ^wdata;

  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    count_d   = count_q;
    state_d   = state_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;

    if (wr_ctrl_s) begin
      ctrl_d = wdata[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_compare_s) begin
      compare_d = wdata[CNT_W-1:0];
    end else begin
      compare_d = compare_q;
    end

    if (wr_count_s) begin
      count_d = wdata[CNT_W-1:0];
    end else if (match_s) begin
      count_d = ctrl_q[CTRL_PERIODIC] ? '0 : compare_q;
    end else if (counting_s) begin
      count_d = count_inc_s;
    end else begin
      count_d = count_q;
    end

    // EN is taken from the incoming write so the state follows it next cycle.
    case (state_q)
      IDLE: begin
        if (ctrl_d[CTRL_EN]) state_d = RUN;
        else                 state_d = IDLE;
      end
      RUN: begin
        if (!ctrl_d[CTRL_EN])                        state_d = IDLE;
        else if (match_s && !ctrl_q[CTRL_PERIODIC])  state_d = DONE;
        else                                         state_d = RUN;
      end
      DONE: begin
        if (!ctrl_d[CTRL_EN]) state_d = IDLE;
        else if (wr_count_s)  state_d = RUN;
        else                  state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (match_s) begin
      pend_d = 1'b1;
    end else if (irq_ack || (wr_status_s && wdata[STAT_PEND])) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (wrap_s) begin
      ovf_d = 1'b1;
    end else if (wr_status_s && wdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (addr)
      ADDR_CTRL:    rd_mux_s = {29'h0, ctrl_q};
      ADDR_COUNT:   rd_mux_s = 32'(count_q);
      ADDR_COMPARE: rd_mux_s = 32'(compare_q);
      ADDR_STATUS:  rd_mux_s = {16'h0, 8'(miss_s), 4'h0, state_q, ovf_q, pend_q};
      default:      rd_mux_s = 32'h0000_0000;
    endcase
    if (rd_en) rdata_d = rd_mux_s;
    else       rdata_d = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 3'b000;
      count_q   <= '0;
      compare_q <= '0;
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      irq_q     <= pend_q & ctrl_q[CTRL_IE];
      rdata_q   <= rdata_d;
    end
  end

`ifdef TIMER_MISS_CNT_EN
  logic [MISS_W-1:0] miss_q, miss_d;

  // Count matches that land while the previous one is still unacknowledged.
  always_comb begin
    miss_d = miss_q;
    if (wr_status_s && wdata[STAT_MISS_CLR]) begin
      miss_d = '0;
    end else if (match_s && pend_q && (miss_q != {MISS_W{1'b1}})) begin
      miss_d = miss_q + MISS_W'(1);
    end else begin
      miss_d = miss_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) miss_q <= '0;
    else       miss_q <= miss_d;
  end

  assign miss_s = miss_q;
`else
  assign miss_s = '0;
`endif

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: doc/tick_timer_irq.md
Name: tick_timer_irq

Overview:
- Downstream consumer of the prescaler counter's terminal pulse. That pulse is a 1-cycle strobe, once every 53 clocks.
- Accumulates strobes into a programmable timer and raises a level interrupt to the pipelined MIPS core on compare match.
- CPU programs and acknowledges it through a small memory-mapped register port driven from the MEM stage.

Parameters:
- CNT_W, 16, width of COUNT and COMPARE registers (valid range 2..32).
- MISS_W, 8, width of missed-match counter (used only with optional feature).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  reset, synchronous, active-high.
- tick_i  in  1  1-cycle strobe from the prescaler counter; each high cycle is one timer tick.
- wr_en  in  1  register write strobe.
- rd_en  in  1  register read strobe.
- addr  in  2  register select: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- irq  out  1  interrupt request, level.
- irq_ack  in  1  1-cycle acknowledge from CPU interrupt logic.

Behaviour:
- Reset values:
  - CTRL=0, COUNT=0, COMPARE=0, STATUS=0, rdata=0, irq=0.
  - State=IDLE.
  - Reset mid-operation aborts everything in one cycle, including a pending irq.
- CTRL bits:
  - [0] EN.
  - [1] PERIODIC (1 = auto-reload, 0 = one-shot).
  - [2] IE (interrupt enable).
  - Other bits ignore writes and read 0.
- STATUS bits:
  - [0] PEND.
  - [1] OVF.
  - [3:2] state encoding (IDLE=0, RUN=1, DONE=2).
  - Other bits read 0 (see optional feature).
- States:
  - IDLE -> RUN when EN=1. Transition effective the cycle after the CTRL write.
  - RUN -> IDLE when EN is written 0; COUNT is held, not cleared.
  - RUN -> DONE on a match when PERIODIC=0.
  - DONE -> RUN on any write to COUNT while EN=1.
  - DONE -> IDLE on EN written 0.
- Counting: only in RUN, only on cycles with tick_i=1. next=COUNT+1 modulo 2^CNT_W.
- Match: on a tick, if COMPARE!=0 and next==COMPARE:
  - PEND is set.
  - PERIODIC=1: COUNT becomes 0 (not COMPARE).
  - PERIODIC=0: COUNT becomes COMPARE and state goes to DONE.
- COMPARE=0 disables matching. COUNT free-runs.
- Wrap: COUNT goes from 2^CNT_W-1 to 0 with no match → OVF set. OVF is sticky, cleared by writing 1 to STATUS[1].
- Register writes:
  - COUNT and COMPARE take wdata[CNT_W-1:0].
  - A COUNT write on a tick cycle: the write wins, with no increment and no match evaluation.
  - A COMPARE write takes effect from the next cycle.
- PEND clear: irq_ack=1, or a write of 1 to STATUS[0]. Writing 0 has no effect.
- Simultaneous match and clear in the same cycle: set wins, so PEND stays 1.
- irq is registered: irq = PEND & IE, asserted the cycle after PEND rises. Latency from match tick to irq is 2 clocks.
- Clearing IE drops irq next cycle; PEND is retained.
- Reads: rdata is updated the cycle after rd_en with the register value as of the rd_en cycle. It holds its value when rd_en=0. Register bits above CNT_W read 0.
- A read of STATUS has no side effects.

Optional Feature:
- Macro: TIMER_MISS_CNT_EN.
- Defined:
  - Adds a MISS_W-bit saturating counter in STATUS[15:8].
  - Increments on each match that occurs while PEND is already 1; saturates at all-ones.
  - Cleared by reset or by writing 1 to STATUS[2].
- Undefined: no counter hardware; STATUS[15:8] reads 0 and STATUS[2] writes are ignored.

Decomposition:
- Shared package timer_pkg holds:
  - register address constants (ADDR_CTRL, ADDR_COUNT, ADDR_COMPARE, ADDR_STATUS).
  - CTRL/STATUS bit-index constants.
  - state enum type (IDLE, RUN, DONE).
- Single module. No sub-module is natural: the register file, FSM and counter are tightly coupled.

Test Plan:
- Basic match, one-shot:
  - Stimulus: tick_i every 53 clocks; write COMPARE=3, then CTRL=0b101 (EN, IE).
  - Required: after the 3rd tick, COUNT=3, state DONE, PEND=1, irq high 2 clocks after that tick; further ticks leave COUNT at 3.
- Periodic with acknowledge:
  - Stimulus: CTRL=0b111, COMPARE=4; irq_ack pulsed 10 clocks after each irq.
  - Required: COUNT sequence 1,2,3,0,1,...; irq rises every 4 ticks (212 clocks); irq low the cycle after PEND clears.
- Set/clear collision:
  - Stimulus: assert irq_ack in the same cycle as a matching tick.
  - Required: PEND remains 1 and irq stays high.
  - With TIMER_MISS_CNT_EN defined: STATUS[15:8] increments on the second match while PEND=1.
- Wrap and COUNT-write priority:
  - Stimulus: CNT_W=16, COMPARE=0, write COUNT=0xFFFF, then one tick.
  - Required: COUNT=0, OVF=1, no irq.
  - Stimulus: a COUNT=0x0010 write on a tick cycle.
  - Required: COUNT reads 0x0010.
- Reset mid-operation:
  - Stimulus: while in RUN with irq=1, pulse reset one cycle.
  - Required: next cycle irq=0, rdata=0, all registers 0, state IDLE; ticks ignored until EN is rewritten.
- Read port:
  - Stimulus: rd_en with addr=3 in state RUN, PEND=1.
  - Required: rdata=0x00000005 one clock later; rdata holds when rd_en=0.
